// File: rtl/seq_alu.sv
// seq_alu: registered, valid/ready handshaked signed ALU with a one-entry
// output register and a multi-cycle shift-add signed multiply.
// Operations: ADD, SUB, AND, OR, XOR, INC, MOV (single cycle) and MUL
// (BW shift-add steps on operand magnitudes, sign applied at the end).
// Optional feature macro: SEQ_ALU_SAT_EN -- when defined, overflowing
// ADD/SUB/INC/MUL results clamp to the most positive / most negative value;
// when undefined, arithmetic wraps modulo 2^BW.
module seq_alu #(
  parameter int BW = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [BW-1:0] in_a,
  input  logic signed [BW-1:0] in_b,
  input  logic [2:0]           opcode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [BW-1:0] out,
  output logic [2:0]           flags
);

  localparam int PW = 2 * BW;
  localparam int CW = $clog2(BW) + 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_INC = 3'b101;
  localparam logic [2:0] OP_MOV = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  localparam logic [BW-1:0] MAX_POS = {1'b0, {(BW-1){1'b1}}};
`ifdef SEQ_ALU_SAT_EN
  localparam logic [BW-1:0] MIN_NEG = {1'b1, {(BW-1){1'b0}}};
`endif

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   mcand_q, mcand_d;
  logic [PW-1:0]   mplier_q, mplier_d;
  logic [PW-1:0]   prod_q, prod_d;
  logic            sign_q, sign_d;
  logic [BW-1:0]   out_q, out_d;
  logic [2:0]      flags_q, flags_d;
  logic            out_valid_q, out_valid_d;

  logic            accept;
  logic            is_mul;
  logic            mul_done;

  logic [BW-1:0]   add_r;
  logic [BW-1:0]   sub_r;
  logic [BW-1:0]   inc_r;
  logic [BW-1:0]   alu_res;
  logic            alu_ovf;

  logic [PW-1:0]   a_ext;
  logic [PW-1:0]   b_ext;
  logic [PW-1:0]   a_mag;
  logic [PW-1:0]   b_mag;
  logic [PW-1:0]   step_sum;
  logic [PW-1:0]   mul_final;
  logic [BW-1:0]   mul_res;
  logic            mul_ovf;

  // Input handshake: only accept in IDLE and when the output register is free or draining
  always_comb begin
    in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
    accept   = in_valid && in_ready;
    is_mul   = (opcode == OP_MUL);
  end

  // Single-cycle operations with overflow detection and optional clamping
  always_comb begin
    add_r   = in_a + in_b;
    sub_r   = in_a - in_b;
    inc_r   = in_a + BW'(1);
    alu_res = '0;
    alu_ovf = 1'b0;
    case (opcode)
      OP_ADD: begin
        alu_res = add_r;
        alu_ovf = (in_a[BW-1] == in_b[BW-1]) && (add_r[BW-1] != in_a[BW-1]);
      end
      OP_SUB: begin
        alu_res = sub_r;
        alu_ovf = (in_a[BW-1] != in_b[BW-1]) && (sub_r[BW-1] != in_a[BW-1]);
      end
      OP_AND: alu_res = in_a & in_b;
      OP_OR:  alu_res = in_a | in_b;
      OP_XOR: alu_res = in_a ^ in_b;
      OP_INC: begin
        alu_res = inc_r;
        alu_ovf = (in_a == MAX_POS);
      end
      OP_MOV: alu_res = in_a;
      default: begin
        alu_res = '0;
        alu_ovf = 1'b0;
      end
    endcase
`ifdef SEQ_ALU_SAT_EN
    // An overflowing ADD/SUB has a true result whose sign is opposite to the
    // wrapped one, which always matches the sign of a; INC can only overflow upward.
    if (alu_ovf) begin
      alu_res = ((opcode == OP_INC) || !in_a[BW-1]) ? MAX_POS : MIN_NEG;
    end
`endif
  end

  // Multiply datapath: magnitudes in double width, one shift-add per step, sign applied last
  always_comb begin
    a_ext     = {{BW{in_a[BW-1]}}, in_a};
    b_ext     = {{BW{in_b[BW-1]}}, in_b};
    a_mag     = in_a[BW-1] ? (PW'(0) - a_ext) : a_ext;
    b_mag     = in_b[BW-1] ? (PW'(0) - b_ext) : b_ext;
    step_sum  = prod_q + (mplier_q[0] ? mcand_q : '0);
    mul_final = sign_q ? (PW'(0) - step_sum) : step_sum;
    mul_ovf   = !((&mul_final[PW-1:BW-1]) || (~|mul_final[PW-1:BW-1]));
    mul_res   = mul_final[BW-1:0];
`ifdef SEQ_ALU_SAT_EN
    if (mul_ovf) begin
      mul_res = sign_q ? MIN_NEG : MAX_POS;
    end
`endif
  end

  // FSM next state: launch a multiply from IDLE, iterate BW steps, then return
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    sign_d   = sign_q;
    mul_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept && is_mul) begin
          state_d  = MUL;
          cnt_d    = '0;
          mcand_d  = a_mag;
          mplier_d = b_mag;
          prod_d   = '0;
          sign_d   = in_a[BW-1] ^ in_b[BW-1];
        end
      end
      MUL: begin
        prod_d   = step_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(BW - 1)) begin
          mul_done = 1'b1;
          state_d  = IDLE;
          cnt_d    = '0;
          mcand_d  = '0;
          mplier_d = '0;
          prod_d   = '0;
          sign_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output register: a new result loads with priority, otherwise hold until consumed
  always_comb begin
    out_d       = out_q;
    flags_d     = flags_q;
    out_valid_d = out_valid_q && !out_ready;
    if (accept && !is_mul) begin
      out_d       = alu_res;
      flags_d     = {alu_ovf, alu_res[BW-1], (alu_res == '0)};
      out_valid_d = 1'b1;
    end else if (mul_done) begin
      out_d       = mul_res;
      flags_d     = {mul_ovf, mul_res[BW-1], (mul_res == '0)};
      out_valid_d = 1'b1;
    end
  end

  // State and datapath registers; reset aborts any multiply in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      prod_q      <= '0;
      sign_q      <= 1'b0;
      out_q       <= '0;
      flags_q     <= 3'b000;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      prod_q      <= prod_d;
      sign_q      <= sign_d;
      out_q       <= out_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out       = out_q;
  assign flags     = flags_q;
  assign out_valid = out_valid_q;

endmodule
